normalizador_pipe: RTL and testbench
====================================

# normalizador_pipe

Parametrised, pipelined successor of the combinational sum/multiply normaliser. It takes one raw add or multiply datapath result per transaction (sign, pre-normalisation exponent, wide significand), then normalises, rounds under a selectable IEEE-754 rounding mode, saturates and packs it into a `1+EXP_W+MAN_W` float. A valid/ready handshake on both sides lets it sit between the FPU arithmetic stage and the result register or bus.

## Interface
- `EXP_W`, 8: exponent field width.
- `MAN_W`, 23: stored mantissa width.
- `MUL_W`, `2*(MAN_W+1)`: product width. Bit `MUL_W-2` has weight 1.0.
- `SUM_W`, `MAN_W+4`: sum width. Bit `SUM_W-2` has weight 1.0; the two LSBs are guard and round.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset. One clock; reset is synchronous and active-low.
- `in_valid` input 1: input transaction valid.
- `in_ready` output 1: block can accept an input this cycle.
- `op_input` input 1: operation select, 0 = sum, 1 = multiply.
- `signo_mul`, `signo_sum` input 1 each: sign for each operation.
- `exp_mul` input EXP_W+2: signed, biased exponent for the product.
- `exp_sum` input EXP_W+2: signed, biased exponent for the sum.
- `producto` input MUL_W: product significand.
- `suma_resul` input SUM_W: sum significand.
- `sum_sticky` input 1: OR of bits the aligner shifted out.
- `rnd_mode` input 2: rounding mode. 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `resultado` output 1+EXP_W+MAN_W: packed float `{sign, exp, man}`.
- `flags` output 4: `{overflow, underflow, inexact, zero}`.

## Operation
- **Stage 1 (select/LZC)**
  - Mux sign, exponent, significand and sticky on `op_input`. For multiply, sticky is the OR of the low product bits below the round bit.
  - Leading-one detect over the full selected width.
  - If the top bit is set, shift right 1 and add 1 to the exponent.
  - Otherwise shift left by the leading-zero count and subtract that count from the exponent.
- **Stage 2 (round)**
  - Extract the MAN_W+1 significand, guard `g`, round `r` and sticky `s`.
  - Round-up condition per mode:
    - RNE: `g & (r|s|lsb)`
    - RTZ: never
    - RUP: `~sign & (g|r|s)`
    - RDN: `sign & (g|r|s)`
  - Carry out of the rounding add sets the significand to `1.0` and adds 1 to the exponent.
  - `inexact = g|r|s`.
- **Stage 3 (pack/saturate)**
  - Significand zero (before normalisation): output `{sign, 0, 0}` with `zero=1`. Sign is preserved.
  - Exponent `>= 2^EXP_W-1`: `overflow=1` and `inexact=1`.
    - RNE returns ±Inf.
    - RUP returns Inf for positive results and max-finite for negative ones.
    - RDN returns Inf for negative results and max-finite for positive ones.
    - RTZ returns max-finite (`{sign, 2^EXP_W-2, all-ones}`).
  - Exponent `<= 0`: flush to `{sign, 0, 0}` with `underflow=1` and `zero=1`. No subnormals are produced.
  - Otherwise pack `{sign, exp[EXP_W-1:0], man[MAN_W-1:0]}`.
- Exponent arithmetic is signed EXP_W+3 bits internally, so no intermediate wrap-around occurs.

## Timing
- 3-stage pipeline with latency exactly 3 cycles: an input accepted at edge N produces `out_valid` after edge N+3, provided there is no stall.
- Global advance: `adv = ~out_valid | out_ready`.
  - `in_ready = adv`, combinational from `out_valid`/`out_ready` only.
  - When `adv=0`, all stage registers hold and the output stays stable.
- Accept occurs when `in_valid & in_ready`.
- Bubbles propagate as `valid=0`. Throughput is 1 result per cycle while `out_ready=1`.
- Simultaneous accept and output consume in the same cycle is legal; both transactions complete.
- Reset (`rst_n=0` at an edge):
  - Clears all stage valid bits, `out_valid=0`, `resultado=0`, `flags=0`.
  - In-flight transactions are discarded, including when reset is asserted mid-stall.
  - `in_ready=1` in the first cycle after reset.
- Input fields are ignored when `in_valid=0`.

## Test plan
- **Multiply 1.5×1.5:** `producto=48'h900000000000`, `exp_mul=127`, sign 0, RNE → `resultado=32'h40100000`, `flags=0000`, appearing 3 cycles after accept.
- **Sum 1.0 and tie:**
  - `suma_resul=27'h2000000`, `exp_sum=127` → `32'h3F800000`.
  - Guard=1, round=0, sticky=0, lsb=0 under RNE → no increment, `inexact=1`.
  - Same with lsb=1 → mantissa increments.
- **Overflow:** multiply, `producto` bit 47 set, `exp_mul=254`.
  - RNE → `32'h7F800000` with overflow flag.
  - RTZ → `32'h7F7FFFFF` with overflow flag.
  - RDN with sign 1 → `32'hFF800000`.
- **Underflow/zero:**
  - Sum, `suma_resul=27'h0800000`, `exp_sum=1`, sign 1 → `32'h80000000`, `flags=0101` (underflow, zero).
  - `suma_resul=0` → `flags=0001`.
- **Back-pressure:** stream 6 back-to-back inputs; hold `out_ready=0` for 4 cycles mid-stream.
  - `in_ready` drops in the same cycle as the stall.
  - No result is lost or duplicated; output order is preserved; `resultado` is stable while stalled.
- **Reset mid-stream:** with 3 transactions in flight, pulse `rst_n=0` for one edge → `out_valid=0` next cycle, and no stale results appear afterwards.

Source files
------------

// File: rtl/normalizador_pipe.sv
// Pipelined normaliser/rounder for raw FPU add and multiply results.
// Four register levels: capture/select, normalise, round, then pack/saturate into the output register.
module normalizador_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int MUL_W = 2*(MAN_W+1),
    parameter int SUM_W = MAN_W+4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_input,
    input  logic                   signo_mul,
    input  logic                   signo_sum,
    input  logic [EXP_W+1:0]       exp_mul,
    input  logic [EXP_W+1:0]       exp_sum,
    input  logic [MUL_W-1:0]       producto,
    input  logic [SUM_W-1:0]       suma_resul,
    input  logic                   sum_sticky,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   resultado,
    output logic [3:0]             flags
);

    localparam int EW    = EXP_W + 3;
    localparam int LZ_W  = $clog2(MUL_W);
    localparam int G_POS = MUL_W - MAN_W - 3;

    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'(2**EXP_W - 1);
    localparam logic [EXP_W-1:0]     EXP_MAXF = EXP_W'(2**EXP_W - 2);

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    function automatic logic [LZ_W-1:0] lzc(input logic [MUL_W-2:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MUL_W - 1);
        for (int i = 0; i < MUL_W-1; i++) begin
            if (v[i]) n = LZ_W'(MUL_W - 2 - i);
        end
        return n;
    endfunction

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Sums are aligned to the product format so both share one datapath.
    // Product low bits stay in the significand and fold into sticky after normalisation.
    logic                   sel_sign;
    logic signed [EW-1:0]   sel_exp;
    logic [MUL_W-1:0]       sel_sig;
    logic                   sel_sticky;

    always_comb begin
        sel_sign   = signo_sum;
        sel_exp    = {exp_sum[EXP_W+1], exp_sum};
        sel_sig    = {suma_resul, {(MUL_W-SUM_W){1'b0}}};
        sel_sticky = sum_sticky;
        if (op_input) begin
            sel_sign   = signo_mul;
            sel_exp    = {exp_mul[EXP_W+1], exp_mul};
            sel_sig    = producto;
            sel_sticky = 1'b0;
        end
    end

    logic                   v0, sign0, sticky0, zero0;
    logic signed [EW-1:0]   exp0;
    logic [MUL_W-1:0]       sig0;
    logic [1:0]             mode0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
        end else if (adv) begin
            v0      <= in_valid;
            sign0   <= sel_sign;
            exp0    <= sel_exp;
            sig0    <= sel_sig;
            sticky0 <= sel_sticky;
            zero0   <= (sel_sig == '0);
            mode0   <= rnd_mode;
        end
    end

    logic [LZ_W-1:0]        lz;
    logic [MUL_W-2:0]       norm_sig;
    logic signed [EW-1:0]   norm_exp;
    logic                   norm_sticky;

    always_comb begin
        lz          = lzc(sig0[MUL_W-2:0]);
        norm_sig    = sig0[MUL_W-2:0] << lz;
        norm_exp    = exp0 - EW'(lz);
        norm_sticky = sticky0;
        if (sig0[MUL_W-1]) begin
            norm_sig    = sig0[MUL_W-1:1];
            norm_exp    = exp0 + EXP_ONE;
            norm_sticky = sticky0 | sig0[0];
        end
    end

    logic                   v1, sign1, sticky1, zero1;
    logic signed [EW-1:0]   exp1;
    logic [MUL_W-2:0]       sig1;
    logic [1:0]             mode1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1      <= v0;
            sign1   <= sign0;
            exp1    <= norm_exp;
            sig1    <= norm_sig;
            sticky1 <= norm_sticky;
            zero1   <= zero0;
            mode1   <= mode0;
        end
    end

    logic [MAN_W:0]         man_full;
    logic                   lsb, g, r, s, rnd_up, carry;
    logic [MAN_W-1:0]       man_rnd;
    logic signed [EW-1:0]   exp_rnd;

    always_comb begin
        man_full = sig1[MUL_W-2 -: MAN_W+1];
        lsb      = sig1[G_POS+1];
        g        = sig1[G_POS];
        r        = sig1[G_POS-1];
        s        = (|sig1[G_POS-2:0]) | sticky1;
        rnd_up   = 1'b0;
        case (mode1)
            RNE:     rnd_up = g & (r | s | lsb);
            RTZ:     rnd_up = 1'b0;
            RUP:     rnd_up = ~sign1 & (g | r | s);
            RDN:     rnd_up = sign1 & (g | r | s);
            default: rnd_up = 1'b0;
        endcase
        // An all-ones significand wraps to 1.0 and bumps the exponent.
        carry   = rnd_up & (&man_full);
        man_rnd = rnd_up ? (man_full[MAN_W-1:0] + MAN_W'(1)) : man_full[MAN_W-1:0];
        exp_rnd = exp1 + {{(EW-1){1'b0}}, carry};
    end

    logic                   v2, sign2, inexact2, zero2;
    logic signed [EW-1:0]   exp2;
    logic [MAN_W-1:0]       man2;
    logic [1:0]             mode2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2       <= v1;
            sign2    <= sign1;
            exp2     <= exp_rnd;
            man2     <= man_rnd;
            inexact2 <= g | r | s;
            zero2    <= zero1;
            mode2    <= mode1;
        end
    end

    logic [EXP_W+MAN_W:0]   res_pk, res_inf, res_maxf;
    logic [3:0]             fl_pk;

    always_comb begin
        res_inf  = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        res_maxf = {sign2, EXP_MAXF, {MAN_W{1'b1}}};
        res_pk   = {sign2, exp2[EXP_W-1:0], man2};
        fl_pk    = {2'b00, inexact2, 1'b0};
        if (zero2) begin
            res_pk = {sign2, {(EXP_W+MAN_W){1'b0}}};
            fl_pk  = 4'b0001;
        end else if (exp2 >= EXP_OVF) begin
            fl_pk = 4'b1010;
            case (mode2)
                RNE:     res_pk = res_inf;
                RUP:     res_pk = sign2 ? res_maxf : res_inf;
                RDN:     res_pk = sign2 ? res_inf : res_maxf;
                default: res_pk = res_maxf;
            endcase
        end else if (exp2 <= EXP_ZERO) begin
            res_pk = {sign2, {(EXP_W+MAN_W){1'b0}}};
            fl_pk  = {1'b0, 1'b1, inexact2, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            resultado <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                resultado <= res_pk;
                flags     <= fl_pk;
            end
        end
    end

endmodule

// File: tb/tb_normalizador_pipe.sv
// Directed self-checking bench for normalizador_pipe (EXP_W=8, MAN_W=23).
module tb_normalizador_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int MUL_W = 48;
    localparam int SUM_W = 27;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 op_input;
    logic                 signo_mul, signo_sum;
    logic [EXP_W+1:0]     exp_mul, exp_sum;
    logic [MUL_W-1:0]     producto;
    logic [SUM_W-1:0]     suma_resul;
    logic                 sum_sticky;
    logic [1:0]           rnd_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [EXP_W+MAN_W:0] resultado;
    logic [3:0]           flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    normalizador_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_input   (op_input),
        .signo_mul  (signo_mul),
        .signo_sum  (signo_sum),
        .exp_mul    (exp_mul),
        .exp_sum    (exp_sum),
        .producto   (producto),
        .suma_resul (suma_resul),
        .sum_sticky (sum_sticky),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resultado  (resultado),
        .flags      (flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
        end
    endtask

    // Unused operand gets junk and the opposite sign so a bad mux shows up.
    task automatic set_in(input logic op, input logic sgn, input logic [9:0] e,
                          input logic [47:0] p, input logic [26:0] s,
                          input logic st, input logic [1:0] m);
        in_valid = 1'b1;
        op_input = op;
        rnd_mode = m;
        if (op) begin
            signo_mul  = sgn;
            exp_mul    = e;
            producto   = p;
            signo_sum  = ~sgn;
            exp_sum    = 10'($urandom_range(0, 1023));
            suma_resul = 27'($urandom);
            sum_sticky = 1'($urandom_range(0, 1));
        end else begin
            signo_sum  = sgn;
            exp_sum    = e;
            suma_resul = s;
            sum_sticky = st;
            signo_mul  = ~sgn;
            exp_mul    = 10'($urandom_range(0, 1023));
            producto   = {16'($urandom), 32'($urandom)};
        end
    endtask

    task automatic run_one(input string tag, input logic op, input logic sgn,
                           input logic [9:0] e, input logic [47:0] p, input logic [26:0] s,
                           input logic st, input logic [1:0] m,
                           input logic [31:0] exp_res, input logic [3:0] exp_fl);
        @(negedge clk);
        out_ready = 1'b1;
        set_in(op, sgn, e, p, s, st, m);
        #1 chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({tag, " lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " lat2"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
        chk({tag, " res"}, 64'(resultado), 64'(exp_res));
        chk({tag, " flags"}, 64'(flags), 64'(exp_fl));
    endtask

    logic [31:0] exp_q [6];
    logic [31:0] held;
    logic        stalled;
    int          sent, rcv;

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_input   = 1'b0;
        signo_mul  = 1'b0;
        signo_sum  = 1'b0;
        exp_mul    = '0;
        exp_sum    = '0;
        producto   = '0;
        suma_resul = '0;
        sum_sticky = 1'b0;
        rnd_mode   = 2'b00;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset resultado", 64'(resultado), 64'd0);
        chk("reset flags", 64'(flags), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        run_one("mul 1.5x1.5",   1, 0, 10'd127, 48'h900000000000, '0, 0, 2'b00, 32'h40100000, 4'b0000);
        run_one("mul 0.5",       1, 0, 10'd127, 48'h200000000000, '0, 0, 2'b00, 32'h3F000000, 4'b0000);
        run_one("sum 1.0",       0, 0, 10'd127, '0, 27'h2000000, 0, 2'b00, 32'h3F800000, 4'b0000);
        run_one("sum tie even",  0, 0, 10'd127, '0, 27'h2000002, 0, 2'b00, 32'h3F800000, 4'b0010);
        run_one("sum tie odd",   0, 0, 10'd127, '0, 27'h2000006, 0, 2'b00, 32'h3F800002, 4'b0010);
        run_one("sum carry in",  0, 0, 10'd127, '0, 27'h4000000, 0, 2'b00, 32'h40000000, 4'b0000);
        run_one("sum rnd carry", 0, 0, 10'd127, '0, 27'h3FFFFFE, 0, 2'b00, 32'h40000000, 4'b0010);
        run_one("sum rup stky",  0, 0, 10'd127, '0, 27'h2000000, 1, 2'b10, 32'h3F800001, 4'b0010);
        run_one("ovf rne",       1, 0, 10'd254, 48'h800000000000, '0, 0, 2'b00, 32'h7F800000, 4'b1010);
        run_one("ovf rtz",       1, 0, 10'd254, 48'h800000000000, '0, 0, 2'b01, 32'h7F7FFFFF, 4'b1010);
        run_one("ovf rdn neg",   1, 1, 10'd254, 48'h800000000000, '0, 0, 2'b11, 32'hFF800000, 4'b1010);
        run_one("ovf rup neg",   1, 1, 10'd254, 48'h800000000000, '0, 0, 2'b10, 32'hFF7FFFFF, 4'b1010);
        run_one("underflow",     0, 1, 10'd1,   '0, 27'h0800000, 0, 2'b00, 32'h80000000, 4'b0101);
        run_one("zero neg",      0, 1, 10'd127, '0, 27'h0000000, 0, 2'b00, 32'h80000000, 4'b0001);

        // Six back-to-back sums with mantissa k+1; output stalls for cycles 5..8.
        for (int k = 0; k < 6; k++) exp_q[k] = 32'h3F800000 + 32'(k + 1);
        sent    = 0;
        rcv     = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c < 9);
            #1;
            if (stalled) chk("bp stable", 64'(resultado), 64'(held));
            stalled = out_valid & ~out_ready;
            held    = resultado;
            if (out_valid && !out_ready) chk("bp in_ready stall", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (rcv < 6) chk("bp order", 64'(resultado), 64'(exp_q[rcv]));
                else chk("bp extra", 64'(rcv), 64'd5);
                rcv++;
            end
            if (sent < 6) begin
                set_in(0, 0, 10'd127, '0, 27'h2000000 | 27'((sent + 1) << 2), 0, 2'b00);
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp sent", 64'(sent), 64'd6);
        chk("bp received", 64'(rcv), 64'd6);

        // Three transactions in flight, then a one-edge reset.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_in(0, 0, 10'd127, '0, 27'h2000000 | 27'((k + 1) << 2), 0, 2'b00);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst resultado", 64'(resultado), 64'd0);
        chk("rst flags", 64'(flags), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst stale", 64'(out_valid), 64'd0);
        end

        run_one("after reset", 1, 0, 10'd127, 48'h900000000000, '0, 0, 2'b00, 32'h40100000, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
